// File: rtl/program_loader_if.sv
// ============================================================================
// Module : program_loader_if
// Brief  : Request handshake and instruction-memory write bus of the loader.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface program_loader_if #(
    parameter int ADDR_W = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_kind;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [15:0]       in_imm;
    logic              seal;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [31:0]       mem_wdata;

    modport master (
        output in_valid, in_kind, in_rs, in_rt, in_rd, in_imm, seal,
        input  in_ready, mem_we, mem_waddr, mem_wdata
    );

    modport slave (
        input  in_valid, in_kind, in_rs, in_rt, in_rd, in_imm, seal,
        output in_ready, mem_we, mem_waddr, mem_wdata
    );
endinterface

`default_nettype wire

// File: rtl/program_loader.sv
// ============================================================================
// Module : program_loader
// Brief  : Encodes instruction requests and writes them into instruction memory.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module program_loader #(
    parameter int DEPTH  = 7,
    parameter int ADDR_W = 3
) (
    input  wire logic        clk,
    input  wire logic        reset,
    program_loader_if.slave  bus,
    output logic [ADDR_W-1:0] count,
    output logic             full,
    output logic             prog_ready,
    output logic             overflow
);

    localparam logic [1:0] S_LOAD  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [ADDR_W-1:0] C_DEPTH = ADDR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] C_ONE   = ADDR_W'(1);

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic [ADDR_W-1:0] r_count;
    logic [ADDR_W-1:0] r_waddr;
    logic [31:0]       r_wdata;
    logic              r_seal_pend;
    logic              r_overflow;
    logic              w_full;
    logic              w_in_ready;
    logic              w_accept;

    function automatic logic [31:0] encode(
        input logic [1:0]  kind,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [15:0] imm
    );
        logic [31:0] word;
        case (kind)
            2'd0:    word = {6'h09, rs, rt, imm};
            2'd1:    word = {6'h00, rs, rt, rd, 5'b0, 6'h21};
            2'd2:    word = {6'h00, rs, rt, rd, 5'b0, 6'h23};
            default: word = 32'h0;
        endcase
        return word;
    endfunction

    assign w_full   = (r_count == C_DEPTH);
    assign w_accept = bus.in_valid && w_in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_LOAD: begin
                if (w_accept) begin
                    w_next_state = S_WRITE;
                end else if (bus.seal) begin
                    w_next_state = S_DONE;
                end
            end
            // A seal seen during accept or during the write itself ends loading here.
            S_WRITE: w_next_state = (r_seal_pend || bus.seal) ? S_DONE : S_LOAD;
            S_DONE:  w_next_state = S_DONE;
            default: w_next_state = S_LOAD;
        endcase
    end

    always_comb begin
        w_in_ready = (r_state == S_LOAD) && !w_full;
        // Gating with reset drops a write that is in flight when reset arrives.
        bus.mem_we = (r_state == S_WRITE) && !reset;
        prog_ready = (r_state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count     <= '0;
            r_waddr     <= '0;
            r_wdata     <= 32'h0;
            r_seal_pend <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_waddr     <= r_count;
                r_wdata     <= encode(bus.in_kind, bus.in_rs, bus.in_rt, bus.in_rd, bus.in_imm);
                r_seal_pend <= bus.seal;
            end
            if (r_state == S_WRITE) begin
                r_count <= r_count + C_ONE;
            end
            if ((r_state == S_LOAD) && w_full && bus.in_valid) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.mem_waddr = r_waddr;
    assign bus.mem_wdata = r_wdata;
    assign count         = r_count;
    assign full          = w_full;
    assign overflow      = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
// ============================================================================
// Module : tb_program_loader
// Brief  : Self-checking bench for program_loader against a queue-based model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_program_loader;

    localparam int DEPTH  = 7;
    localparam int ADDR_W = 3;

    logic clk;
    logic reset;
    logic [ADDR_W-1:0] count;
    logic full;
    logic prog_ready;
    logic overflow;

    int checks   = 0;
    int failures = 0;

    program_loader_if #(.ADDR_W(ADDR_W)) bus ();

    program_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus.slave),
        .count      (count),
        .full       (full),
        .prog_ready (prog_ready),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed memory writes, plus any write seen while in_ready was high.
    int          wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          ready_viol = 0;

    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            wr_addr_q.push_back(int'(bus.mem_waddr));
            wr_data_q.push_back(bus.mem_wdata);
            if (bus.in_ready !== 1'b0) ready_viol++;
        end
    end

    // Expected words in write order; address is the position in the queue.
    logic [31:0] exp_q[$];

    function automatic logic [31:0] model_word(input int kind, input int rs, input int rt,
                                               input int rd, input int imm);
        longint w;
        case (kind)
            0:       w = 9 * 64'd67108864 + rs * 64'd2097152 + rt * 64'd65536 + (imm & 'hFFFF);
            1:       w = rs * 64'd2097152 + rt * 64'd65536 + rd * 64'd2048 + 33;
            2:       w = rs * 64'd2097152 + rt * 64'd65536 + rd * 64'd2048 + 35;
            default: w = 0;
        endcase
        return w[31:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid = 1'b0;
        bus.seal     = 1'b0;
        bus.in_kind  = 2'($urandom);
        bus.in_rs    = 5'($urandom);
        bus.in_rt    = 5'($urandom);
        bus.in_rd    = 5'($urandom);
        bus.in_imm   = 16'($urandom);
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        wr_addr_q.delete();
        wr_data_q.delete();
        exp_q.delete();
        ready_viol = 0;
    endtask

    // Presents one request and returns #1 after the accepting edge (the WRITE cycle).
    task automatic send(input int kind, input int rs, input int rt, input int rd,
                        input int imm, input bit with_seal);
        int t;
        bus.in_kind  = 2'(kind);
        bus.in_rs    = 5'(rs);
        bus.in_rt    = 5'(rt);
        bus.in_rd    = 5'(rd);
        bus.in_imm   = 16'(imm);
        bus.in_valid = 1'b1;
        bus.seal     = with_seal;
        t = 0;
        while (bus.in_ready !== 1'b1 && t < 20) begin
            step();
            t++;
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL send_timeout: in_ready=%b required 1 within 20 cycles", bus.in_ready);
        end
        step();
        idle_inputs();
        exp_q.push_back(model_word(kind, rs, rt, rd, imm));
    endtask

    task automatic test_reset();
        do_reset();
        step();
        checks++;
        if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b required 1", bus.in_ready); end
        checks++;
        if (count !== 0 || full !== 1'b0 || prog_ready !== 1'b0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_status: count=%0d full=%b prog_ready=%b overflow=%b required 0 0 0 0",
                     count, full, prog_ready, overflow);
        end
        checks++;
        if (bus.mem_we !== 1'b0 || bus.mem_waddr !== 0 || bus.mem_wdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_mem: we=%b waddr=%0d wdata=%h required 0 0 00000000",
                     bus.mem_we, bus.mem_waddr, bus.mem_wdata);
        end
    endtask

    task automatic test_addiu();
        do_reset();
        send(0, 0, 1, 0, 45, 1'b0);
        checks++;
        if (bus.mem_we !== 1'b1 || bus.mem_waddr !== 0 || bus.mem_wdata !== 32'h2401002D) begin
            failures++;
            $display("FAIL addiu_write: we=%b waddr=%0d wdata=%h required 1 0 2401002d",
                     bus.mem_we, bus.mem_waddr, bus.mem_wdata);
        end
        checks++;
        if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL addiu_ready_in_write: got %b required 0", bus.in_ready); end
        step();
        checks++;
        if (count !== 1 || bus.mem_we !== 1'b0) begin
            failures++;
            $display("FAIL addiu_count: count=%0d we=%b required 1 0", count, bus.mem_we);
        end
    endtask

    task automatic test_sequence();
        logic [31:0] fixed [3];
        do_reset();
        send(0, 0, 2, 0, -20, 1'b0);
        send(1, 1, 2, 5, 0, 1'b0);
        send(2, 5, 6, 5, 0, 1'b0);
        step();
        fixed[0] = 32'h2402FFEC;
        fixed[1] = 32'h00222821;
        fixed[2] = 32'h00A62823;
        checks++;
        if (wr_data_q.size() != 3) begin
            failures++;
            $display("FAIL seq_write_count: got %0d required 3", wr_data_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (wr_addr_q[i] != i || wr_data_q[i] !== fixed[i]) begin
                    failures++;
                    $display("FAIL seq_word%0d: addr=%0d data=%h required %0d %h",
                             i, wr_addr_q[i], wr_data_q[i], i, fixed[i]);
                end
            end
        end
        checks++;
        if (ready_viol != 0) begin failures++; $display("FAIL seq_ready_in_write: %0d writes with in_ready high, required 0", ready_viol); end
    endtask

    task automatic test_full_overflow();
        do_reset();
        bus.in_kind  = 2'd3;
        bus.in_valid = 1'b1;
        repeat (20) step();
        bus.in_valid = 1'b0;
        checks++;
        if (wr_data_q.size() != DEPTH) begin
            failures++;
            $display("FAIL full_write_count: got %0d required %0d", wr_data_q.size(), DEPTH);
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                checks++;
                if (wr_addr_q[i] != i || wr_data_q[i] !== 32'h0) begin
                    failures++;
                    $display("FAIL full_word%0d: addr=%0d data=%h required %0d 00000000",
                             i, wr_addr_q[i], wr_data_q[i], i);
                end
            end
        end
        checks++;
        if (full !== 1'b1 || bus.in_ready !== 1'b0 || overflow !== 1'b1 || count !== DEPTH) begin
            failures++;
            $display("FAIL full_status: full=%b in_ready=%b overflow=%b count=%0d required 1 0 1 %0d",
                     full, bus.in_ready, overflow, count, DEPTH);
        end
        bus.seal = 1'b1;
        step();
        bus.seal = 1'b0;
        step();
        checks++;
        if (prog_ready !== 1'b1 || wr_data_q.size() != DEPTH) begin
            failures++;
            $display("FAIL full_seal: prog_ready=%b writes=%0d required 1 %0d",
                     prog_ready, wr_data_q.size(), DEPTH);
        end
    endtask

    task automatic test_seal_with_accept();
        do_reset();
        send(1, 3, 4, 7, 0, 1'b1);
        checks++;
        if (bus.mem_we !== 1'b1 || bus.mem_wdata !== exp_q[0]) begin
            failures++;
            $display("FAIL sealacc_write: we=%b wdata=%h required 1 %h", bus.mem_we, bus.mem_wdata, exp_q[0]);
        end
        step();
        checks++;
        if (prog_ready !== 1'b1 || count !== 1) begin
            failures++;
            $display("FAIL sealacc_done: prog_ready=%b count=%0d required 1 1", prog_ready, count);
        end
        bus.in_valid = 1'b1;
        repeat (4) step();
        bus.in_valid = 1'b0;
        checks++;
        if (wr_data_q.size() != 1 || overflow !== 1'b0 || bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL sealacc_ignore: writes=%0d overflow=%b in_ready=%b required 1 0 0",
                     wr_data_q.size(), overflow, bus.in_ready);
        end
    endtask

    task automatic test_reset_mid_write();
        do_reset();
        for (int i = 0; i < 3; i++) send(1, i, i + 1, i + 2, 0, 1'b0);
        send(0, 1, 1, 0, 7, 1'b0);
        reset = 1'b1;
        #1;
        checks++;
        if (bus.mem_we !== 1'b0) begin failures++; $display("FAIL midreset_we: got %b required 0", bus.mem_we); end
        step();
        reset = 1'b0;
        checks++;
        if (count !== 0 || prog_ready !== 1'b0 || wr_data_q.size() != 3) begin
            failures++;
            $display("FAIL midreset_state: count=%0d prog_ready=%b writes=%0d required 0 0 3",
                     count, prog_ready, wr_data_q.size());
        end
        send(0, 0, 3, 0, 99, 1'b0);
        checks++;
        if (bus.mem_we !== 1'b1 || bus.mem_waddr !== 0 || bus.mem_wdata !== exp_q[$]) begin
            failures++;
            $display("FAIL midreset_reload: we=%b waddr=%0d wdata=%h required 1 0 %h",
                     bus.mem_we, bus.mem_waddr, bus.mem_wdata, exp_q[$]);
        end
    endtask

    task automatic test_seal_no_loads();
        do_reset();
        bus.seal = 1'b1;
        step();
        bus.seal = 1'b0;
        step();
        checks++;
        if (prog_ready !== 1'b1 || count !== 0 || wr_data_q.size() != 0) begin
            failures++;
            $display("FAIL seal_empty: prog_ready=%b count=%0d writes=%0d required 1 0 0",
                     prog_ready, count, wr_data_q.size());
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            int n;
            bit seal_last;
            do_reset();
            n = int'($urandom_range(0, DEPTH));
            seal_last = 1'($urandom);
            for (int k = 0; k < n; k++) begin
                repeat ($urandom_range(0, 2)) step();
                send(int'($urandom_range(0, 3)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                     int'($urandom_range(0, 31)), int'($urandom_range(0, 65535)),
                     seal_last && (k == n - 1));
            end
            if (!(seal_last && n > 0)) begin
                step();
                bus.seal = 1'b1;
                step();
                bus.seal = 1'b0;
            end
            repeat (2) step();
            checks++;
            if (wr_data_q.size() != exp_q.size()) begin
                failures++;
                $display("FAIL rand%0d_count: writes=%0d required %0d", it, wr_data_q.size(), exp_q.size());
            end else begin
                for (int i = 0; i < exp_q.size(); i++) begin
                    checks++;
                    if (wr_addr_q[i] != i || wr_data_q[i] !== exp_q[i]) begin
                        failures++;
                        $display("FAIL rand%0d_word%0d: addr=%0d data=%h required %0d %h",
                                 it, i, wr_addr_q[i], wr_data_q[i], i, exp_q[i]);
                    end
                end
            end
            checks++;
            if (count !== n || full !== (n == DEPTH) || prog_ready !== 1'b1 || overflow !== 1'b0 || ready_viol != 0) begin
                failures++;
                $display("FAIL rand%0d_status: count=%0d full=%b prog_ready=%b overflow=%b viol=%0d required %0d %b 1 0 0",
                         it, count, full, prog_ready, overflow, ready_viol, n, (n == DEPTH));
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_addiu();
        test_sequence();
        test_full_overflow();
        test_seal_with_accept();
        test_reset_mid_write();
        test_seal_no_loads();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
